if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  IF-stage fetch engine; the write-side producer of the IF/ID pipeline register. Holds the PC and
//  fetches from instruction memory over a req/ack handshake. Presents IF_Instruction/IF_PCadd4 plus a
//  valid flag to IF/ID; honours the stall (PCWre) and redirect (branch/jump flush) from hazard/branch logic.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC value loaded on reset; bits [1:0] must be 0
// PORTS
//  Clk             in   1   single clock; all state changes on posedge
//  Reset           in   1   asynchronous, active-low reset
//  PCWre           in   1   1 = IF/ID consumes the output slot this cycle; 0 = stall, hold
//  Redirect        in   1   branch/jump taken; kills all fetched and in-flight instructions
//  RedirectPC      in   32  new PC; bits [1:0] ignored (forced 00)
//  IMem_Req        out  1   fetch request
//  IMem_Addr       out  32  fetch address; stable while IMem_Req=1 and IMem_Ack=0
//  IMem_Ack        in   1   memory accepts request; IMem_RData valid this cycle (may be same cycle as Req)
//  IMem_RData      in   32  instruction word
//  IF_Instruction  out  32  fetched instruction; 32'h0 (nop) when IF_Valid=0
//  IF_PCadd4       out  32  address of IF_Instruction + 4; 0 when IF_Valid=0
//  IF_Valid        out  1   output slot holds a live instruction
// BEHAVIOUR
//  Reset (async assert): PC=RESET_PC, state FETCH, IMem_Req=0, IMem_Addr=RESET_PC, IF_Valid=0,
//   IF_Instruction=0, IF_PCadd4=0, pending reg empty. IMem_Req rises on first posedge after release.
//  Registers: PC (next fetch), ReqAddr (drives IMem_Addr), output slot, one pending reg (skid).
//  At most one request outstanding. Request completes at a posedge with IMem_Req=1 and IMem_Ack=1.
//  Slot "free" at a posedge = IF_Valid=0 or PCWre=1.
//  FSM:
//   FETCH  : Req=1, Addr=ReqAddr. On Ack: data to slot if free, else to pending reg -> HOLD;
//            PC<=PC+4, ReqAddr<=PC+4. No Ack: stay; consumed slot empties (IF_Valid<=0, fields<=0).
//   HOLD   : Req=0. When PCWre=1: pending -> slot, -> FETCH. PCWre=0: slot, pending, PC all hold.
//   DISCARD: Req=1 at stale ReqAddr until Ack; Ack data dropped; then ReqAddr<=PC, -> FETCH.
//  Redirect (highest priority, any state): slot and pending cleared (IF_Valid<=0, fields<=0);
//   PC<=RedirectPC. If a request is outstanding and not acked this cycle -> DISCARD (stale addr held);
//   otherwise ReqAddr<=RedirectPC -> FETCH. Redirect in DISCARD updates PC, stays DISCARD.
//  Simultaneous Ack + PCWre with full slot: new data replaces slot, IF_Valid stays 1 (no bubble).
//  Stale instruction after Redirect never reaches IF_Valid=1.
//  Arithmetic: PC+4 modulo 2^32 (0xFFFF_FFFC wraps to 0). IF_PCadd4 = fetch address + 4, same wrap.
//  Latency: Ack at edge N -> IF_Instruction valid after edge N; zero-wait memory = 1 instr/cycle.
//  Reset mid-request: Req drops immediately; memory must tolerate abandoned request.
// CONFIGURATION
//  IF_PERF_CNT_EN defined: adds outputs FetchCnt[31:0] (completed fetches delivered to slot),
//   StallCnt[31:0] (cycles IF_Valid=1 and PCWre=0), KillCnt[31:0] (live or in-flight instrs killed
//   by Redirect). All reset to 0, wrap modulo 2^32.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Release reset, zero-wait mem (Ack=Req), PCWre=1 -> IMem_Addr 0,4,8,...; IF_PCadd4 4,8,12; no bubbles.
//  2 After 2 fetches, PCWre=0 for 3 cycles -> 1 extra word in pending, Req=0, outputs held; on PCWre=1
//     sequence resumes with no duplicate/skipped PC.
//  3 Mem latency 3, Redirect to 0x40 one cycle after Req at 0x8 -> Addr holds 0x8 until Ack, data
//     dropped, next Req at 0x40, IF_Valid=0 throughout, first valid IF_PCadd4=0x44.
//  4 Redirect to 0x100 coincident with Ack and PCWre=1 -> slot cleared, next IMem_Addr=0x100.
//  5 RESET_PC=32'hFFFF_FFFC -> first IF_PCadd4=0, second IMem_Addr=0.
//  6 Assert Reset mid-request (latency 3) -> Req=0 and outputs 0 without clock; with IF_PERF_CNT_EN
//     after test 3 KillCnt=1 and StallCnt=3 after test 2.

Source files
------------

// File: rtl/if_fetch_unit.sv
// IF-stage fetch engine: owns the PC, fetches over a req/ack memory handshake and fills the IF/ID slot.
// Optional performance counters (FetchCnt/StallCnt/KillCnt) are compiled in when IF_PERF_CNT_EN is defined.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Ack,
  input  logic [31:0] IMem_RData,
  output logic [31:0] IF_Instruction,
  output logic [31:0] IF_PCadd4,
  output logic        IF_Valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] FetchCnt,
  output logic [31:0] StallCnt,
  output logic [31:0] KillCnt
`endif
);

  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

  state_t      state, state_nxt;
  logic        running;
  logic [31:0] pc, pc_nxt;
  logic [31:0] req_addr, req_addr_nxt;
  logic        slot_valid, slot_valid_nxt;
  logic [31:0] slot_instr, slot_instr_nxt;
  logic [31:0] slot_pcadd4, slot_pcadd4_nxt;
  logic [31:0] pend_instr, pend_instr_nxt;
  logic [31:0] pend_pcadd4, pend_pcadd4_nxt;

  logic        req, acked, slot_free;
  logic [31:0] addr_inc, redirect_pc;

  // Request is suppressed for the first cycle after reset and while holding a skid word.
  assign req         = running && (state != HOLD);
  assign acked       = req && IMem_Ack;
  assign slot_free   = !slot_valid || PCWre;
  assign addr_inc    = req_addr + 32'd4;
  assign redirect_pc = {RedirectPC[31:2], 2'b00};

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    req_addr_nxt    = req_addr;
    slot_valid_nxt  = slot_valid;
    slot_instr_nxt  = slot_instr;
    slot_pcadd4_nxt = slot_pcadd4;
    pend_instr_nxt  = pend_instr;
    pend_pcadd4_nxt = pend_pcadd4;
    if (Redirect) begin
      slot_valid_nxt  = 1'b0;
      slot_instr_nxt  = 32'h0;
      slot_pcadd4_nxt = 32'h0;
      pend_instr_nxt  = 32'h0;
      pend_pcadd4_nxt = 32'h0;
      pc_nxt          = redirect_pc;
      // An unanswered request must still complete at its stale address before we move on.
      if (req && !IMem_Ack) begin
        state_nxt = DISCARD;
      end else begin
        req_addr_nxt = redirect_pc;
        state_nxt    = FETCH;
      end
    end else begin
      case (state)
        FETCH: begin
          if (acked) begin
            pc_nxt       = addr_inc;
            req_addr_nxt = addr_inc;
            if (slot_free) begin
              slot_valid_nxt  = 1'b1;
              slot_instr_nxt  = IMem_RData;
              slot_pcadd4_nxt = addr_inc;
            end else begin
              pend_instr_nxt  = IMem_RData;
              pend_pcadd4_nxt = addr_inc;
              state_nxt       = HOLD;
            end
          end else if (PCWre) begin
            slot_valid_nxt  = 1'b0;
            slot_instr_nxt  = 32'h0;
            slot_pcadd4_nxt = 32'h0;
          end
        end
        HOLD: begin
          if (PCWre) begin
            slot_valid_nxt  = 1'b1;
            slot_instr_nxt  = pend_instr;
            slot_pcadd4_nxt = pend_pcadd4;
            pend_instr_nxt  = 32'h0;
            pend_pcadd4_nxt = 32'h0;
            state_nxt       = FETCH;
          end
        end
        DISCARD: begin
          if (PCWre) begin
            slot_valid_nxt  = 1'b0;
            slot_instr_nxt  = 32'h0;
            slot_pcadd4_nxt = 32'h0;
          end
          if (acked) begin
            req_addr_nxt = pc;
            state_nxt    = FETCH;
          end
        end
        default: state_nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= FETCH;
      running     <= 1'b0;
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      slot_valid  <= 1'b0;
      slot_instr  <= 32'h0;
      slot_pcadd4 <= 32'h0;
      pend_instr  <= 32'h0;
      pend_pcadd4 <= 32'h0;
    end else begin
      state       <= state_nxt;
      running     <= 1'b1;
      pc          <= pc_nxt;
      req_addr    <= req_addr_nxt;
      slot_valid  <= slot_valid_nxt;
      slot_instr  <= slot_instr_nxt;
      slot_pcadd4 <= slot_pcadd4_nxt;
      pend_instr  <= pend_instr_nxt;
      pend_pcadd4 <= pend_pcadd4_nxt;
    end
  end

  assign IMem_Req       = req;
  assign IMem_Addr      = req_addr;
  assign IF_Instruction = slot_instr;
  assign IF_PCadd4      = slot_pcadd4;
  assign IF_Valid       = slot_valid;

`ifdef IF_PERF_CNT_EN
  logic       fetch_inc, stall_inc;
  logic [1:0] kill_amt;

  // Kills cover the slot, the skid word, and a live in-flight request (DISCARD ones were already counted).
  assign fetch_inc = !Redirect && (((state == FETCH) && acked && slot_free) || ((state == HOLD) && PCWre));
  assign stall_inc = slot_valid && !PCWre;
  assign kill_amt  = Redirect ? ({1'b0, slot_valid} + {1'b0, state == HOLD} + {1'b0, (state == FETCH) && req})
                              : 2'd0;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      FetchCnt <= 32'h0;
      StallCnt <= 32'h0;
      KillCnt  <= 32'h0;
    end else begin
      FetchCnt <= FetchCnt + {31'h0, fetch_inc};
      StallCnt <= StallCnt + {31'h0, stall_inc};
      KillCnt  <= KillCnt + {30'h0, kill_amt};
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a latency-programmable memory responder plus a queue of
// expected fetch addresses (refilled on reset/redirect) that is drained as IF/ID consumes the slot.
module tb_if_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        PCWre;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        IMem_Req;
  logic [31:0] IMem_Addr;
  logic        IMem_Ack;
  logic [31:0] IMem_RData;
  logic [31:0] IF_Instruction;
  logic [31:0] IF_PCadd4;
  logic        IF_Valid;

  logic        req2;
  logic [31:0] addr2, instr2, pcadd42;
  logic        valid2;

`ifdef IF_PERF_CNT_EN
  logic [31:0] FetchCnt, StallCnt, KillCnt;
  logic [31:0] fetchCnt2, stallCnt2, killCnt2;
  logic [31:0] stall0, kill0;
`endif

  int checkCount = 0;
  int errorCount = 0;
  int popCnt = 0;
  int memLatency = 0;
  int waitCnt;
  int pop0;
  int n;
  logic [31:0] expQ[$];
  logic [31:0] expAddr;

  always #5 Clk = ~Clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h5A5A_0001;
  endfunction

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .Clk(Clk), .Reset(Reset), .PCWre(PCWre), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .IMem_Req(IMem_Req), .IMem_Addr(IMem_Addr), .IMem_Ack(IMem_Ack), .IMem_RData(IMem_RData),
    .IF_Instruction(IF_Instruction), .IF_PCadd4(IF_PCadd4), .IF_Valid(IF_Valid)
`ifdef IF_PERF_CNT_EN
    , .FetchCnt(FetchCnt), .StallCnt(StallCnt), .KillCnt(KillCnt)
`endif
  );

  // Second instance exercises the wrap-around reset vector with a zero-wait memory.
  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .Clk(Clk), .Reset(Reset), .PCWre(1'b1), .Redirect(1'b0), .RedirectPC(32'h0),
    .IMem_Req(req2), .IMem_Addr(addr2), .IMem_Ack(req2), .IMem_RData(memWord(addr2)),
    .IF_Instruction(instr2), .IF_PCadd4(pcadd42), .IF_Valid(valid2)
`ifdef IF_PERF_CNT_EN
    , .FetchCnt(fetchCnt2), .StallCnt(stallCnt2), .KillCnt(killCnt2)
`endif
  );

  // Memory answers after memLatency idle cycles of a held request.
  always @(posedge Clk or negedge Reset) begin
    if (!Reset) waitCnt <= 0;
    else if (IMem_Req && !IMem_Ack) waitCnt <= waitCnt + 1;
    else waitCnt <= 0;
  end
  assign IMem_Ack   = IMem_Req && (waitCnt >= memLatency);
  assign IMem_RData = memWord(IMem_Addr);

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic loadStream(input logic [31:0] base);
    expQ.delete();
    for (int i = 0; i < 128; i++) expQ.push_back(base + 32'(4 * i));
  endtask

  task automatic applyStimulus(input logic [31:0] target);
    Redirect   = 1'b1;
    RedirectPC = target;
    loadStream({target[31:2], 2'b00});
    tick();
    Redirect = 1'b0;
  endtask

  task automatic waitFreshReq(input logic [31:0] addr, input string tag);
    int k;
    k = 0;
    while (!(IMem_Req && IMem_Addr == addr && waitCnt == 0) && k < 50) begin
      tick();
      k++;
    end
    checkOutput(tag, 32'(k < 50), 32'd1);
  endtask

  // Consumption happens at the coming posedge when the slot is valid, PCWre=1 and no flush.
  always @(negedge Clk) begin
    if (Reset) begin
      if (IF_Valid && PCWre && !Redirect) begin
        if (expQ.size() == 0) begin
          checkOutput("sb underflow", 32'd1, 32'd0);
        end else begin
          expAddr = expQ.pop_front();
          checkOutput("sb pcadd4", IF_PCadd4, expAddr + 32'd4);
          checkOutput("sb instr", IF_Instruction, memWord(expAddr));
        end
        popCnt++;
      end else if (!IF_Valid) begin
        checkOutput("nop instr", IF_Instruction, 32'h0);
        checkOutput("nop pcadd4", IF_PCadd4, 32'h0);
      end
    end
  end

  initial begin
    Reset = 1'b0; PCWre = 1'b1; Redirect = 1'b0; RedirectPC = 32'h0; memLatency = 0;
    #12;
    checkOutput("rst req", 32'(IMem_Req), 32'd0);
    checkOutput("rst addr", IMem_Addr, 32'h0);
    checkOutput("rst valid", 32'(IF_Valid), 32'd0);
    checkOutput("rst instr", IF_Instruction, 32'h0);
    checkOutput("rst pcadd4", IF_PCadd4, 32'h0);
    checkOutput("rst wrap addr", addr2, 32'hFFFF_FFFC);
    @(posedge Clk); #1;
    Reset = 1'b1;
    loadStream(32'h0);

    tick();
    checkOutput("t1 req rise", 32'(IMem_Req), 32'd1);
    checkOutput("t1 addr0", IMem_Addr, 32'h0);
    tick();
    checkOutput("t1 valid", 32'(IF_Valid), 32'd1);
    checkOutput("t1 pcadd4", IF_PCadd4, 32'h4);
    checkOutput("t5 wrap pcadd4", pcadd42, 32'h0);
    checkOutput("t5 wrap addr2", addr2, 32'h0);
    pop0 = popCnt;
    repeat (4) tick();
    checkOutput("t1 no bubbles", 32'(popCnt - pop0), 32'd4);
    checkOutput("t1 addr", IMem_Addr, 32'h14);

`ifdef IF_PERF_CNT_EN
    stall0 = StallCnt;
`endif
    PCWre = 1'b0;
    tick();
    checkOutput("t2 req low", 32'(IMem_Req), 32'd0);
    checkOutput("t2 hold pcadd4", IF_PCadd4, 32'h14);
    tick();
    tick();
    checkOutput("t2 req still low", 32'(IMem_Req), 32'd0);
    checkOutput("t2 held pcadd4", IF_PCadd4, 32'h14);
    checkOutput("t2 held valid", 32'(IF_Valid), 32'd1);
`ifdef IF_PERF_CNT_EN
    checkOutput("t2 stallcnt", StallCnt - stall0, 32'd3);
`endif
    PCWre = 1'b1;
    repeat (4) tick();

    repeat (40) begin
      PCWre = 1'($urandom_range(0, 1));
      memLatency = $urandom_range(0, 2);
      tick();
    end
    PCWre = 1'b1;

    memLatency = 3;
    applyStimulus(32'h8);
    waitFreshReq(32'h8, "t3 req at 8");
    tick();
`ifdef IF_PERF_CNT_EN
    kill0 = KillCnt;
`endif
    applyStimulus(32'h40);
    checkOutput("t3 stale addr", IMem_Addr, 32'h8);
    checkOutput("t3 stale req", 32'(IMem_Req), 32'd1);
    checkOutput("t3 valid0 a", 32'(IF_Valid), 32'd0);
    tick();
    checkOutput("t3 stale addr hold", IMem_Addr, 32'h8);
    checkOutput("t3 valid0 b", 32'(IF_Valid), 32'd0);
    tick();
    checkOutput("t3 new addr", IMem_Addr, 32'h40);
    checkOutput("t3 valid0 c", 32'(IF_Valid), 32'd0);
`ifdef IF_PERF_CNT_EN
    checkOutput("t3 killcnt", KillCnt - kill0, 32'd1);
`endif
    n = 0;
    while (!IF_Valid && n < 20) begin
      tick();
      n++;
    end
    checkOutput("t3 first valid", 32'(IF_Valid), 32'd1);
    checkOutput("t3 first pcadd4", IF_PCadd4, 32'h44);

    memLatency = 0;
    repeat (4) tick();
    checkOutput("t4 req", 32'(IMem_Req), 32'd1);
    checkOutput("t4 slot full", 32'(IF_Valid), 32'd1);
    applyStimulus(32'h102);
    checkOutput("t4 cleared", 32'(IF_Valid), 32'd0);
    checkOutput("t4 instr0", IF_Instruction, 32'h0);
    checkOutput("t4 addr", IMem_Addr, 32'h100);
    repeat (3) tick();

    applyStimulus(32'hFFFF_FFF8);
    repeat (5) tick();
    checkOutput("wrap addr", IMem_Addr, 32'hC);

    memLatency = 3;
    applyStimulus(32'h200);
    waitFreshReq(32'h200, "t6 req at 200");
    tick();
    #2;
    Reset = 1'b0;
    #1;
    checkOutput("t6 req drop", 32'(IMem_Req), 32'd0);
    checkOutput("t6 addr", IMem_Addr, 32'h0);
    checkOutput("t6 valid", 32'(IF_Valid), 32'd0);
    checkOutput("t6 instr", IF_Instruction, 32'h0);
    checkOutput("t6 pcadd4", IF_PCadd4, 32'h0);
`ifdef IF_PERF_CNT_EN
    checkOutput("t6 killcnt rst", KillCnt, 32'h0);
    checkOutput("t6 fetchcnt rst", FetchCnt, 32'h0);
`endif
    tick();
    Reset = 1'b1;
    memLatency = 0;
    loadStream(32'h0);
    tick();
    checkOutput("t6 restart req", 32'(IMem_Req), 32'd1);
    checkOutput("t6 restart addr", IMem_Addr, 32'h0);
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
